v6510_bus_master: RTL and testbench
===================================

V6510_BUS_MASTER -- requirements
Module: v6510_bus_master

Interface
REQ-001 Parameter HOLD_CLKS, default 2, clk cycles that write data and address stay driven after the detected phi2 fall.
REQ-002 Parameter MAX_RETRY, default 255, number of bus cycles lost to AEC low before a request is abandoned.
REQ-003 clk  in  1  the single block clock (>=8x phi2); all logic is clocked on its rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 phi2  in  1  board phi2, asynchronous to clk.
REQ-006 aec  in  1  address enable control, asynchronous to clk; low means the VIC owns the bus.
REQ-007 req_valid / req_ready  in / out  1 / 1  request handshake; a transfer occurs when both are high on a clk edge.
REQ-008 req_addr / req_wdata / req_write  in  16 / 8 / 1  request payload; req_write=1 means a write cycle.
REQ-009 rsp_valid  out  1  one-clk pulse: request completed or abandoned.
REQ-010 rsp_rdata / rsp_err  out  8 / 1  read data and abandon flag, both valid while rsp_valid is high.
REQ-011 address_6510 / address_oe  out  16 / 1  bus address and its enable; a top-level tristate drives the pins.
REQ-012 r_w_6510  out  1  bus R/_W, 1 = read; driven under address_oe.
REQ-013 data_6510_out / data_oe / data_6510_in  out / out / in  8 / 1 / 8  bus write data, its enable, and bus read data.

Function
REQ-014 phi2 and aec pass through 2-FF synchronizers; phi2 rise and fall are single-clk pulses taken from the synchronized signal.
REQ-015 States are IDLE, ARM, PHI1, PHI2, HOLD and RESP.
REQ-016 IDLE: req_ready=1 and all enables are 0; a handshake latches the payload, sets the retry count to 0 and enters ARM.
REQ-017 req_ready is 1 only in IDLE; one request is outstanding at a time.
REQ-018 ARM: on the phi2 fall, if synchronized aec=1, enter PHI1.
REQ-019 ARM: on the phi2 fall, if aec=0, increment the retry count and stay in ARM.
REQ-020 When the retry count reaches MAX_RETRY, go to RESP with rsp_err=1.
REQ-021 PHI1: address_oe=1 and address/R_W are driven from the latched request; on the phi2 rise enter PHI2.
REQ-022 PHI2, write: data_oe=1 with data_6510_out=req_wdata from the first PHI2 clk.
REQ-023 PHI2, read: data_6510_in is registered into a capture register on every clk of PHI2.
REQ-024 PHI2: on the phi2 fall enter HOLD; the read result is the capture value from before the fall pulse, never a sample taken on or after it.
REQ-025 If synchronized aec goes low in PHI1 or PHI2, all enables drop in the same clk, the retry count increments, the state returns to ARM, and no response is produced.
REQ-026 HOLD: address_oe stays high, and for writes data_oe stays high, for HOLD_CLKS clks, counted by a down-counter; then go to RESP.
REQ-027 RESP: rsp_valid=1 for exactly one clk, with rsp_rdata = capture value (0 for writes) and rsp_err as set; then go to IDLE.
REQ-028 A phi2 rise seen in ARM is ignored; a cycle always starts on a fall.
REQ-029 Accesses to $0000/$0001 are passed to the bus unchanged; the port registers live in the CPU-side adapter.

Reset
REQ-030 While reset is high, the state is IDLE and req_ready=0.
REQ-031 While reset is high, address_oe=0, data_oe=0, rsp_valid=0 and rsp_err=0.
REQ-032 While reset is high, address_6510=0, r_w_6510=1, data_6510_out=0, rsp_rdata=0, and all counters and the capture register are 0.
REQ-033 Reset mid-cycle drops every enable in the same clk and discards the request without any response.
REQ-034 The synchronizer flops reset to 0, so no edge pulse is generated in the first two clks after reset releases.

Structure
REQ-035 The shared package v6510_pkg holds the state enum, HOLD_CLKS/MAX_RETRY defaults and the synchronizer depth constant.
REQ-036 One sub-module, v6510_sync_edge, holds the 2-FF synchronizer and rise/fall pulse logic; it is instantiated twice (phi2 with edges, aec with level only).

Verification
REQ-037 clk 16 MHz, phi2 1 MHz 50%, aec=1; read $D020 with the bus returning $F3 -> address_oe high over one full phi1+phi2 period, r_w_6510=1, rsp_rdata=$F3, rsp_err=0.
REQ-038 Write $0001=$37 -> data_oe high from PHI2 entry until 2 clks after the fall is detected, r_w_6510=0, address $0001, rsp_valid once.
REQ-039 aec held low for 3 phi2 periods, then high; read $1000 -> no enables during the aec-low cycles, access completes on the 4th cycle, rsp_err=0.
REQ-040 MAX_RETRY=4, aec stuck low -> rsp_valid with rsp_err=1 after 4 phi2 falls; address_oe never asserted.
REQ-041 aec drops mid-PHI2 of a write -> enables drop within 3 clks, the cycle is retried next phi1, exactly one rsp_valid.
REQ-042 reset asserted mid-PHI2 of a write -> enables 0 on the next clk, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/v6510_pkg.sv
// Shared definitions for the 6510 bus master: FSM states, parameter defaults
// and synchronizer depth.
package v6510_pkg;

  localparam int HOLD_CLKS_DEF = 2;
  localparam int MAX_RETRY_DEF = 255;
  localparam int SYNC_DEPTH    = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_PHI1 = 3'd2,
    ST_PHI2 = 3'd3,
    ST_HOLD = 3'd4,
    ST_RESP = 3'd5
  } state_t;

endpackage

// File: rtl/v6510_sync_edge.sv
// Multi-flop synchronizer for an asynchronous board signal, with optional
// single-clk rise/fall pulses derived from the synchronized level.
module v6510_sync_edge
  import v6510_pkg::*;
#(
  parameter bit EDGES = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_p0;
  logic                  level_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      level_p1 <= 1'b0;
    end else begin
      sync_p0  <= {sync_p0[SYNC_DEPTH-2:0], async_in};
      level_p1 <= sync_p0[SYNC_DEPTH-1];
    end
  end

  // Edge pulses compare the synchronized level with its one-clk-old copy
  assign level = sync_p0[SYNC_DEPTH-1];
  assign rise  = EDGES & level & ~level_p1;
  assign fall  = EDGES & ~level & level_p1;

endmodule

// File: rtl/v6510_bus_master.sv
// 6510-style bus master: turns single read/write requests into phi2-timed bus
// cycles, yielding to the VIC while AEC is low and retrying up to a limit.
module v6510_bus_master
  import v6510_pkg::*;
#(
  parameter int HOLD_CLKS = HOLD_CLKS_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2,
  input  logic        aec,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_write,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] address_6510,
  output logic        address_oe,
  output logic        r_w_6510,
  output logic [7:0]  data_6510_out,
  output logic        data_oe,
  input  logic [7:0]  data_6510_in
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int HOLD_W  = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;

  state_t               state;
  state_t               state_nxt;
  logic                 phi2_s;
  logic                 phi2_rise;
  logic                 phi2_fall;
  logic                 aec_s;
  logic                 aec_rise_unused;
  logic                 aec_fall_unused;
  logic [15:0]          addr_q;
  logic [7:0]           wdata_q;
  logic                 write_q;
  logic [7:0]           cap_q;
  logic                 err_q;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [RETRY_W-1:0]   retry_inc;
  logic                 retry_hit;
  logic                 retry_bump;
  logic                 lose_bus;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 accept;

  v6510_sync_edge #(.EDGES(1'b1)) u_phi2_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (phi2),
    .level    (phi2_s),
    .rise     (phi2_rise),
    .fall     (phi2_fall)
  );

  v6510_sync_edge #(.EDGES(1'b0)) u_aec_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (aec),
    .level    (aec_s),
    .rise     (aec_rise_unused),
    .fall     (aec_fall_unused)
  );

  assign accept     = req_valid & req_ready;
  assign lose_bus   = ((state == ST_PHI1) || (state == ST_PHI2)) && !aec_s;
  assign retry_bump = lose_bus || ((state == ST_ARM) && phi2_fall && !aec_s);
  assign retry_inc  = retry_cnt + 1'b1;
  assign retry_hit  = (retry_inc == RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_ARM;
      end
      // A bus cycle only ever starts on a detected phi2 fall
      ST_ARM: begin
        if (phi2_fall) begin
          if (aec_s)          state_nxt = ST_PHI1;
          else if (retry_hit) state_nxt = ST_RESP;
        end
      end
      ST_PHI1: begin
        if (!aec_s)         state_nxt = retry_hit ? ST_RESP : ST_ARM;
        else if (phi2_rise) state_nxt = ST_PHI2;
      end
      ST_PHI2: begin
        if (!aec_s)         state_nxt = retry_hit ? ST_RESP : ST_ARM;
        else if (phi2_fall) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt == '0) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      cap_q     <= '0;
      err_q     <= 1'b0;
      retry_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      if (accept) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        write_q   <= req_write;
        cap_q     <= '0;
        err_q     <= 1'b0;
        retry_cnt <= '0;
      end
      if (retry_bump) begin
        retry_cnt <= retry_inc;
        if (retry_hit) err_q <= 1'b1;
      end
      if ((state == ST_PHI2) && aec_s && phi2_fall) begin
        hold_cnt <= HOLD_W'(HOLD_CLKS - 1);
      end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      // The sample on the fall-pulse clk may already be past the bus hold time
      if ((state == ST_PHI2) && !phi2_fall) begin
        cap_q <= data_6510_in;
      end
    end
  end

  always_comb begin
    req_ready     = 1'b0;
    address_oe    = 1'b0;
    data_oe       = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    address_6510  = '0;
    r_w_6510      = 1'b1;
    data_6510_out = '0;
    if (!reset) begin
      case (state)
        ST_IDLE: req_ready = 1'b1;
        ST_PHI1: address_oe = aec_s;
        ST_PHI2: begin
          address_oe = aec_s;
          data_oe    = aec_s & write_q;
        end
        ST_HOLD: begin
          address_oe = 1'b1;
          data_oe    = write_q;
        end
        ST_RESP: begin
          rsp_valid = 1'b1;
          rsp_rdata = write_q ? 8'h00 : cap_q;
          rsp_err   = err_q;
        end
        default: ;
      endcase
      if (address_oe) begin
        address_6510 = addr_q;
        r_w_6510     = ~write_q;
      end
      if (data_oe) data_6510_out = wdata_q;
    end
  end

endmodule

// File: tb/tb_v6510_bus_master.sv
// Directed bench for v6510_bus_master: 16 MHz clk, 1 MHz phi2, hand-computed
// enable lengths, read data, retry and reset behaviour.
`timescale 1ns/1ps
module tb_v6510_bus_master;

  logic        clk;
  logic        reset;
  logic        phi2;
  logic        aec;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_write;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] address_6510;
  logic        address_oe;
  logic        r_w_6510;
  logic [7:0]  data_6510_out;
  logic        data_oe;
  logic [7:0]  data_6510_in;

  logic        aec4;
  logic        req4_valid;
  logic        req4_ready;
  logic        rsp4_valid;
  logic [7:0]  rsp4_rdata;
  logic        rsp4_err;
  logic [15:0] address4;
  logic        address4_oe;
  logic        r_w4;
  logic [7:0]  data4_out;
  logic        data4_oe;

  int          vectors;
  int          miscompares;
  logic [7:0]  bus_rd;
  int          fall_total;
  int          fall_base;
  logic        mon_clr;
  int          aoe_cnt, doe_cnt, aoe_rise_cnt, rsp_cnt, aoe_first_fall;
  logic        aoe_prev;
  logic [15:0] seen_addr;
  logic        seen_rw;
  logic [7:0]  seen_wd;
  logic [7:0]  seen_rdata;
  logic        seen_err;
  int          rsp4_cnt, aoe4_cnt, rsp4_fall;
  logic        seen4_err;

  v6510_bus_master dut (
    .clk           (clk),
    .reset         (reset),
    .phi2          (phi2),
    .aec           (aec),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_write     (req_write),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .address_6510  (address_6510),
    .address_oe    (address_oe),
    .r_w_6510      (r_w_6510),
    .data_6510_out (data_6510_out),
    .data_oe       (data_oe),
    .data_6510_in  (data_6510_in)
  );

  v6510_bus_master #(.HOLD_CLKS(2), .MAX_RETRY(4)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .phi2          (phi2),
    .aec           (aec4),
    .req_valid     (req4_valid),
    .req_ready     (req4_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_write     (req_write),
    .rsp_valid     (rsp4_valid),
    .rsp_rdata     (rsp4_rdata),
    .rsp_err       (rsp4_err),
    .address_6510  (address4),
    .address_oe    (address4_oe),
    .r_w_6510      (r_w4),
    .data_6510_out (data4_out),
    .data_oe       (data4_oe),
    .data_6510_in  (data_6510_in)
  );

  initial begin
    clk = 1'b0;
    forever #31.25 clk = ~clk;
  end

  initial begin
    phi2 = 1'b0;
    #13;
    forever begin
      phi2 = ~phi2;
      #500;
    end
  end

  // Bus model: read data valid 50 ns into phi2, held 100 ns past the fall
  initial begin
    data_6510_in = 8'hEE;
    forever begin
      @(phi2);
      if (phi2) begin
        #50 data_6510_in = bus_rd;
      end else begin
        #100 data_6510_in = 8'hEE;
      end
    end
  end

  always @(negedge phi2) fall_total <= fall_total + 1;

  always @(negedge clk) begin
    if (mon_clr) begin
      aoe_cnt        <= 0;
      doe_cnt        <= 0;
      aoe_rise_cnt   <= 0;
      rsp_cnt        <= 0;
      aoe_first_fall <= -1;
      aoe_prev       <= 1'b0;
      rsp4_cnt       <= 0;
      aoe4_cnt       <= 0;
      rsp4_fall      <= -1;
    end else begin
      aoe_prev <= address_oe;
      if (address_oe) begin
        aoe_cnt   <= aoe_cnt + 1;
        seen_addr <= address_6510;
        seen_rw   <= r_w_6510;
        if (!aoe_prev) begin
          aoe_rise_cnt <= aoe_rise_cnt + 1;
          if (aoe_rise_cnt == 0) aoe_first_fall <= fall_total - fall_base;
        end
      end
      if (data_oe) begin
        doe_cnt <= doe_cnt + 1;
        seen_wd <= data_6510_out;
      end
      if (rsp_valid) begin
        rsp_cnt    <= rsp_cnt + 1;
        seen_rdata <= rsp_rdata;
        seen_err   <= rsp_err;
      end
      if (address4_oe) aoe4_cnt <= aoe4_cnt + 1;
      if (rsp4_valid) begin
        rsp4_cnt  <= rsp4_cnt + 1;
        rsp4_fall <= fall_total - fall_base;
        seen4_err <= rsp4_err;
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic issue(input bit to4, input logic [15:0] a, input logic [7:0] d, input logic w);
    int n;
    n = 0;
    @(posedge phi2);
    repeat (2) @(negedge clk);
    while (((to4 ? req4_ready : req_ready) !== 1'b1) && (n < 64)) begin
      @(negedge clk);
      n++;
    end
    check_vec("req_ready", to4 ? req4_ready : req_ready, 1);
    req_addr  = a;
    req_wdata = d;
    req_write = w;
    if (to4) req4_valid = 1'b1;
    else     req_valid  = 1'b1;
    fall_base = fall_total;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req4_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input bit to4);
    int n;
    n = 0;
    while (((to4 ? rsp4_cnt : rsp_cnt) == 0) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    check_vec({tag, "_done"}, ((to4 ? rsp4_cnt : rsp_cnt) != 0), 1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    vectors    = 0;
    miscompares = 0;
    fall_total = 0;
    fall_base  = 0;
    mon_clr    = 1'b0;
    bus_rd     = 8'hF3;
    reset      = 1'b1;
    aec        = 1'b1;
    aec4       = 1'b0;
    req_valid  = 1'b0;
    req4_valid = 1'b0;
    req_addr   = 16'h0000;
    req_wdata  = 8'h00;
    req_write  = 1'b0;

    repeat (4) @(negedge clk);
    check_vec("rst_ready", req_ready, 0);
    check_vec("rst_aoe", address_oe, 0);
    check_vec("rst_doe", data_oe, 0);
    check_vec("rst_rspv", rsp_valid, 0);
    check_vec("rst_err", rsp_err, 0);
    check_vec("rst_addr", address_6510, 16'h0000);
    check_vec("rst_rw", r_w_6510, 1);
    check_vec("rst_dout", data_6510_out, 8'h00);
    check_vec("rst_rdata", rsp_rdata, 8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("idle_ready", req_ready, 1);

    // Read $D020, bus returns $F3
    clear_mon();
    issue(1'b0, 16'hD020, 8'h00, 1'b0);
    wait_rsp("rd", 1'b0);
    check_vec("rd_rdata", seen_rdata, 8'hF3);
    check_vec("rd_err", seen_err, 0);
    check_vec("rd_aoe_clks", aoe_cnt, 18);
    check_vec("rd_doe_clks", doe_cnt, 0);
    check_vec("rd_addr", seen_addr, 16'hD020);
    check_vec("rd_rw", seen_rw, 1);
    check_vec("rd_first_fall", aoe_first_fall, 1);
    check_vec("rd_rsp_cnt", rsp_cnt, 1);

    // Write $0001 = $37 (port address goes straight to the bus)
    clear_mon();
    issue(1'b0, 16'h0001, 8'h37, 1'b1);
    wait_rsp("wr", 1'b0);
    check_vec("wr_aoe_clks", aoe_cnt, 18);
    check_vec("wr_doe_clks", doe_cnt, 10);
    check_vec("wr_addr", seen_addr, 16'h0001);
    check_vec("wr_rw", seen_rw, 0);
    check_vec("wr_dout", seen_wd, 8'h37);
    check_vec("wr_rdata", seen_rdata, 8'h00);
    check_vec("wr_err", seen_err, 0);
    check_vec("wr_rsp_cnt", rsp_cnt, 1);

    // AEC low for three phi2 periods, read $1000
    bus_rd = 8'h5A;
    aec = 1'b0;
    clear_mon();
    issue(1'b0, 16'h1000, 8'h00, 1'b0);
    repeat (3) @(negedge phi2);
    @(posedge phi2);
    check_vec("aec_no_aoe", aoe_cnt, 0);
    aec = 1'b1;
    wait_rsp("aec", 1'b0);
    check_vec("aec_first_fall", aoe_first_fall, 4);
    check_vec("aec_aoe_clks", aoe_cnt, 18);
    check_vec("aec_rdata", seen_rdata, 8'h5A);
    check_vec("aec_err", seen_err, 0);
    check_vec("aec_rsp_cnt", rsp_cnt, 1);

    // MAX_RETRY=4 instance with AEC stuck low
    clear_mon();
    issue(1'b1, 16'h4000, 8'h00, 1'b0);
    wait_rsp("mr", 1'b1);
    check_vec("mr_err", seen4_err, 1);
    check_vec("mr_falls", rsp4_fall, 4);
    check_vec("mr_aoe_clks", aoe4_cnt, 0);
    check_vec("mr_rsp_cnt", rsp4_cnt, 1);

    // AEC drops in the middle of PHI2 of a write, then the cycle is retried
    clear_mon();
    issue(1'b0, 16'h2000, 8'h55, 1'b1);
    @(negedge phi2);
    @(posedge phi2);
    #250;
    check_vec("mid_doe_pre", data_oe, 1);
    aec = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("mid_doe_drop", data_oe, 0);
    check_vec("mid_aoe_drop", address_oe, 0);
    aec = 1'b1;
    wait_rsp("mid", 1'b0);
    check_vec("mid_rsp_cnt", rsp_cnt, 1);
    check_vec("mid_err", seen_err, 0);
    check_vec("mid_aoe_rises", aoe_rise_cnt, 2);
    check_vec("mid_dout", seen_wd, 8'h55);

    // Reset in the middle of PHI2 of a write
    clear_mon();
    issue(1'b0, 16'h3000, 8'hAA, 1'b1);
    @(negedge phi2);
    @(posedge phi2);
    #250;
    @(negedge clk);
    check_vec("rstw_doe_pre", data_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    check_vec("rstw_doe", data_oe, 0);
    check_vec("rstw_aoe", address_oe, 0);
    check_vec("rstw_ready", req_ready, 0);
    check_vec("rstw_addr", address_6510, 16'h0000);
    check_vec("rstw_rw", r_w_6510, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("rstw_ready_after", req_ready, 1);
    repeat (40) @(negedge clk);
    check_vec("rstw_no_rsp", rsp_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
